autoconfig_chain: RTL and testbench
===================================

# autoconfig_chain

Parametrised Zorro II AutoConfig responder and internal-cycle acknowledge engine for up to four boards (FastRAM or I/O) on the accelerator.
- Sits between the 68000 bus and the board-local resources, all in the CPU_CLK domain.
- Presents each board's configuration ROM in turn at $E8xxxx and latches each assigned base address.
- Decodes configured boards to select lines and generates DTACK_n for all internal cycles with a parametrised wait-state count.

## Interface
- NUM_BOARDS, 2, number of chained boards (1..4).
- WAIT_STATES, 1, extra CPU_CLK cycles between cycle detect and DTACK_n assertion (0..7).
- BOARD_ROM, {FastRAM table, 64 KB I/O table}, 80 bits per board: 20 bus nibbles for word offsets $00..$13, offset 0 in bits [3:0]. Values are raw bus values (already inverted where AutoConfig requires).
- BOARD_MASK, {8'hF0, 8'hFF}, 8 bits per board: compare mask on ADDRESS[23:16].
- CPU_CLK  in  1  sole clock; all state updates on rising edge.
- RESET  in  1  synchronous, active-high reset.
- CPU_AS_n, RW, UDS_n, LDS_n  in  1 each  68000 strobes, pre-synchronised to CPU_CLK.
- ADDRESS  in  23  A23..A1.
- DATA_IN  in  4  D15..D12.
- DATA_OUT  out  4  AutoConfig read nibble.
- DATA_OE  out  1  drive D15..D12.
- DTACK_n  out  1  internal-cycle acknowledge.
- BOARD_SEL  out  NUM_BOARDS  per-board hit, for RAM_CS_n / IDE decode.
- CONFIGURED  out  NUM_BOARDS  board configured or shut up.
- INTERNAL_ACCESS  out  1  current address is internal (AutoConfig window or configured board).

## Operation
- Active board = lowest index with CONFIGURED=0. The AutoConfig window ($E8xxxx) is decoded only while an active board exists.
- Board i hit: CONFIGURED[i] && base[i] valid && (ADDRESS[23:16] & mask_i) == (base_i & mask_i). BOARD_SEL[i] = hit && !CPU_AS_n, combinational.
- FSM states:
  - IDLE: CPU_AS_n low && INTERNAL_ACCESS → WAIT, counter loaded with WAIT_STATES.
  - WAIT: counter decrements; at 0 → ACK.
  - ACK: DTACK_n low; stays until CPU_AS_n sampled high → IDLE.
  - External cycles never leave IDLE.
- AutoConfig reads:
  - ADDRESS[7:6]==0 and ADDRESS[5:1]<20: DATA_OUT = ROM nibble of the active board.
  - Otherwise DATA_OUT = 4'hF.
  - Nibble is latched on entering WAIT. DATA_OE is high in WAIT and ACK, low in IDLE.
- AutoConfig writes take effect once, on the WAIT→ACK transition:
  - word $25 (byte $4A): base_i[3:0] ← DATA_IN.
  - word $24 (byte $48): base_i[7:4] ← DATA_IN; CONFIGURED[i] ← 1; base valid.
  - word $26 (byte $4C): shut-up (see Configuration).
  - Any other write is acknowledged and ignored.
- Board i's configured range and the AutoConfig window are mutually exclusive by construction. If both decode in the same cycle, AutoConfig wins.

## Timing
- Reset values:
  - FSM IDLE; DTACK_n=1; DATA_OE=0; DATA_OUT=4'hF.
  - CONFIGURED=0; bases 0 and invalid; BOARD_SEL=0.
- DTACK_n falls WAIT_STATES+1 rising edges after the edge that sampled CPU_AS_n low. With WAIT_STATES=0 this is the next edge.
- DTACK_n rises on the edge after CPU_AS_n is sampled high.
- Back-to-back cycles: the next cycle is detected in IDLE only. This guarantees at least one IDLE clock.
- CPU_AS_n rising during WAIT (aborted cycle): return to IDLE, no write commit, DTACK_n stays high.
- RESET mid-cycle: immediate return to reset values, including CONFIGURED. The chain restarts at board 0.
- Active board index advances on the same edge the commit happens. The next AutoConfig read sees the next board.

## Configuration
- AUTOCONFIG_SHUTUP_EN defined: a write to word $26 sets CONFIGURED[i]=1 with base invalid. The board never hits, and the chain advances.
- AUTOCONFIG_SHUTUP_EN undefined: a write to $26 is acknowledged and ignored. The board stays active until a $48 write.

## Test plan
- Reset, WAIT_STATES=1, read $E80000: DATA_OUT=4'hE, DATA_OE=1, DTACK_n low 2 clocks after AS_n sampled low; read $E80080 returns 4'hF.
- Write $4A=4'h0 then $48=4'h2 → CONFIGURED=2'b01; read $E80002 now returns board 1 offset-$01 nibble.
- After board 0 at $20: access $2A1234 → BOARD_SEL=2'b01, DTACK_n asserted; access $400000 → BOARD_SEL=0, DTACK_n stays high, FSM remains IDLE.
- With AUTOCONFIG_SHUTUP_EN, write $4C on board 1 → CONFIGURED=2'b11, $E8xxxx no longer internal, BOARD_SEL[1] never asserts; without the macro CONFIGURED stays 2'b01.
- AS_n deasserted during WAIT on a $48 write → no commit, CONFIGURED unchanged, DTACK_n never low.
- RESET pulsed while in ACK → DTACK_n=1 next edge, CONFIGURED=0, read $E80000 returns 4'hE again.

Source files
------------

// File: rtl/autoconfig_chain.sv
// Zorro II AutoConfig responder and internal-cycle DTACK_n generator for a chain of boards.
// Define AUTOCONFIG_SHUTUP_EN to make a word $26 write retire the active board unconfigured.
//   state  | meaning
//   S_IDLE | no internal cycle, waiting for CPU_AS_n low on an internal address
//   S_WAIT | wait-state down-counter running, AutoConfig nibble driven
//   S_ACK  | DTACK_n low until CPU_AS_n is sampled high
module autoconfig_chain #(
    parameter int NUM_BOARDS  = 2,
    parameter int WAIT_STATES = 1,
    parameter logic [NUM_BOARDS*80-1:0] BOARD_ROM = {
        80'hFFFF_FFFF_FFFF_FFFF_FD1C,
        80'hAFFF_FFFF_FFFF_FFFF_F75E
    },
    parameter logic [NUM_BOARDS*8-1:0] BOARD_MASK = {8'hFF, 8'hF0}
) (
    input  logic                  CPU_CLK,
    input  logic                  RESET,
    input  logic                  CPU_AS_n,
    input  logic                  RW,
    input  logic                  UDS_n,
    input  logic                  LDS_n,
    input  logic [23:1]           ADDRESS,
    input  logic [3:0]            DATA_IN,
    output logic [3:0]            DATA_OUT,
    output logic                  DATA_OE,
    output logic                  DTACK_n,
    output logic [NUM_BOARDS-1:0] BOARD_SEL,
    output logic [NUM_BOARDS-1:0] CONFIGURED,
    output logic                  INTERNAL_ACCESS
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK} state_t;

    localparam logic [2:0] WS_LOAD = 3'(WAIT_STATES);

    state_t                       state_q, state_d;
    logic [2:0]                   cnt_q;
    logic [3:0]                   data_q;
    logic                         ac_cyc_q;
    logic [NUM_BOARDS-1:0]        configured_q, base_valid_q, board_hit;
    logic [NUM_BOARDS-1:0][7:0]   base_q;
    logic [1:0]                   active_idx;
    logic                         active_ok;
    logic [79:0]                  active_rom;
    logic [3:0]                   rom_nibble;
    logic                         ac_hit, reg_page, rom_offset_ok, ds_any, commit;

    always_comb begin
        active_idx = '0;
        active_ok  = 1'b0;
        for (int i = NUM_BOARDS - 1; i >= 0; i--) begin
            if (!configured_q[i]) begin
                active_idx = 2'(i);
                active_ok  = 1'b1;
            end
        end
    end

    always_comb begin
        active_rom = BOARD_ROM[79:0];
        for (int i = 1; i < NUM_BOARDS; i++)
            if (active_idx == 2'(i)) active_rom = BOARD_ROM[i*80 +: 80];
    end

    always_comb begin
        rom_nibble = 4'hF;
        for (int n = 0; n < 20; n++)
            if (ADDRESS[5:1] == 5'(n)) rom_nibble = active_rom[n*4 +: 4];
    end

    always_comb begin
        board_hit = '0;
        for (int i = 0; i < NUM_BOARDS; i++)
            board_hit[i] = configured_q[i] && base_valid_q[i] &&
                ((ADDRESS[23:16] & BOARD_MASK[i*8 +: 8]) == (base_q[i] & BOARD_MASK[i*8 +: 8]));
    end

    // Registers only occupy the first 256 bytes of the window; the rest of $E8xxxx reads $F.
    assign ac_hit          = active_ok && (ADDRESS[23:16] == 8'hE8);
    assign reg_page        = (ADDRESS[15:8] == 8'h00);
    assign rom_offset_ok   = (ADDRESS[7:6] == 2'b00) && (ADDRESS[5:1] < 5'd20);
    assign ds_any          = !UDS_n || !LDS_n;
    assign INTERNAL_ACCESS = ac_hit || (|board_hit);
    assign BOARD_SEL       = (ac_hit || CPU_AS_n) ? '0 : board_hit;
    assign CONFIGURED      = configured_q;
    assign DATA_OUT        = data_q;

    always_ff @(posedge CPU_CLK) begin
        if (RESET) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (!CPU_AS_n && INTERNAL_ACCESS) state_d = S_WAIT;
            S_WAIT: begin
                if (CPU_AS_n)           state_d = S_IDLE;
                else if (cnt_q == 3'd0) state_d = S_ACK;
            end
            S_ACK:  if (CPU_AS_n) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        DTACK_n = 1'b1;
        DATA_OE = 1'b0;
        case (state_q)
            S_WAIT: DATA_OE = 1'b1;
            S_ACK: begin
                DTACK_n = 1'b0;
                DATA_OE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            data_q   <= 4'hF;
            ac_cyc_q <= 1'b0;
        end else if (state_q == S_IDLE && state_d == S_WAIT) begin
            cnt_q    <= WS_LOAD;
            ac_cyc_q <= ac_hit;
            data_q   <= (ac_hit && RW && ds_any && reg_page && rom_offset_ok) ? rom_nibble : 4'hF;
        end else if (state_q == S_WAIT && cnt_q != 3'd0) begin
            cnt_q <= cnt_q - 3'd1;
        end
    end

    // Writes land only on the edge that acknowledges, so an aborted cycle never commits.
    assign commit = (state_q == S_WAIT) && (state_d == S_ACK) && ac_cyc_q && active_ok &&
                    !RW && !UDS_n && reg_page;

    always_ff @(posedge CPU_CLK) begin
        if (RESET) begin
            configured_q <= '0;
            base_valid_q <= '0;
            base_q       <= '0;
        end else if (commit) begin
            for (int i = 0; i < NUM_BOARDS; i++) begin
                if (active_idx == 2'(i)) begin
                    case (ADDRESS[7:1])
                        7'h25: base_q[i][3:0] <= DATA_IN;
                        7'h24: begin
                            base_q[i][7:4]  <= DATA_IN;
                            configured_q[i] <= 1'b1;
                            base_valid_q[i] <= 1'b1;
                        end
`ifdef AUTOCONFIG_SHUTUP_EN
                        7'h26: begin
                            configured_q[i] <= 1'b1;
                            base_valid_q[i] <= 1'b0;
                        end
`else
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_autoconfig_chain.sv
// Directed bench for autoconfig_chain: table of AutoConfig transactions plus hand-written corner sequences.
module tb_autoconfig_chain;

    localparam int NB      = 2;
    localparam int WS      = 1;
    // Negedges from driving CPU_AS_n low until DTACK_n is observed low: sampling edge + WS + 1.
    localparam int EXP_LAT = WS + 2;

    logic          clk = 1'b0;
    logic          rst, as_n, rw, uds_n, lds_n;
    logic [23:1]   addr;
    logic [3:0]    din, dout;
    logic          oe, dtack_n, internal;
    logic [NB-1:0] sel, cfg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    autoconfig_chain #(.NUM_BOARDS(NB), .WAIT_STATES(WS)) dut (
        .CPU_CLK(clk), .RESET(rst), .CPU_AS_n(as_n), .RW(rw), .UDS_n(uds_n), .LDS_n(lds_n),
        .ADDRESS(addr), .DATA_IN(din), .DATA_OUT(dout), .DATA_OE(oe), .DTACK_n(dtack_n),
        .BOARD_SEL(sel), .CONFIGURED(cfg), .INTERNAL_ACCESS(internal)
    );

    typedef struct {
        logic [23:0] a;
        logic        rw;
        logic [3:0]  d;
        logic [3:0]  exp_nib;
        logic [1:0]  exp_cfg;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic set_bus(input logic [23:0] a, input logic as_i, input logic rw_i, input logic [3:0] d);
        addr  = a[23:1];
        rw    = rw_i;
        din   = d;
        as_n  = as_i;
        uds_n = as_i;
        lds_n = as_i;
    endtask

    task automatic release_bus();
        as_n  = 1'b1;
        uds_n = 1'b1;
        lds_n = 1'b1;
    endtask

    task automatic do_cycle(input logic [23:0] a, input logic rw_i, input logic [3:0] d,
                            output int lat, output logic [3:0] nib, output logic oe_s,
                            output logic [NB-1:0] sel_s);
        lat   = 0;
        nib   = 4'hx;
        oe_s  = 1'b0;
        sel_s = '0;
        @(negedge clk);
        set_bus(a, 1'b0, rw_i, d);
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (!dtack_n) begin
                lat   = n;
                nib   = dout;
                oe_s  = oe;
                sel_s = sel;
                break;
            end
        end
        release_bus();
        @(negedge clk);
        chk("dtack_release", dtack_n, 1'b1);
        chk("oe_release", oe, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int                 lat, bad, got;
        logic [3:0]         nib;
        logic               oe_s;
        logic [NB-1:0]      sel_s;

        vecs[0] = '{24'hE80000, 1'b1, 4'h0, 4'hE, 2'b00};
        vecs[1] = '{24'hE80002, 1'b1, 4'h0, 4'h5, 2'b00};
        vecs[2] = '{24'hE80004, 1'b1, 4'h0, 4'h7, 2'b00};
        vecs[3] = '{24'hE80026, 1'b1, 4'h0, 4'hA, 2'b00};
        vecs[4] = '{24'hE80028, 1'b1, 4'h0, 4'hF, 2'b00};
        vecs[5] = '{24'hE80080, 1'b1, 4'h0, 4'hF, 2'b00};
        vecs[6] = '{24'hE8004A, 1'b0, 4'h0, 4'h0, 2'b00};
        vecs[7] = '{24'hE80048, 1'b0, 4'h2, 4'h0, 2'b01};
        vecs[8] = '{24'hE80002, 1'b1, 4'h0, 4'h1, 2'b01};
        vecs[9] = '{24'hE80000, 1'b1, 4'h0, 4'hC, 2'b01};

        rst = 1'b1;
        set_bus(24'h000000, 1'b1, 1'b1, 4'h0);
        repeat (3) @(negedge clk);
        chk("rst_dtack", dtack_n, 1'b1);
        chk("rst_oe", oe, 1'b0);
        chk("rst_dout", dout, 4'hF);
        chk("rst_cfg", cfg, 2'b00);
        chk("rst_sel", sel, 2'b00);
        chk("rst_internal_low", internal, 1'b0);
        rst = 1'b0;
        set_bus(24'hE80000, 1'b1, 1'b1, 4'h0);
        #1;
        chk("ac_window_internal", internal, 1'b1);

        for (int i = 0; i < 10; i++) begin
            do_cycle(vecs[i].a, vecs[i].rw, vecs[i].d, lat, nib, oe_s, sel_s);
            chk($sformatf("v%0d_lat", i), lat, EXP_LAT);
            chk($sformatf("v%0d_oe", i), oe_s, 1'b1);
            if (vecs[i].rw) chk($sformatf("v%0d_nib", i), nib, vecs[i].exp_nib);
            chk($sformatf("v%0d_cfg", i), cfg, vecs[i].exp_cfg);
        end

        // Board 0 now at $20 with mask $F0.
        @(negedge clk);
        set_bus(24'h2A1234, 1'b1, 1'b1, 4'h0);
        #1;
        chk("b0_sel_as_high", sel, 2'b00);
        chk("b0_internal", internal, 1'b1);
        do_cycle(24'h2A1234, 1'b1, 4'h0, lat, nib, oe_s, sel_s);
        chk("b0_lat", lat, EXP_LAT);
        chk("b0_sel", sel_s, 2'b01);

        @(negedge clk);
        set_bus(24'h400000, 1'b0, 1'b1, 4'h0);
        #1;
        chk("ext_sel", sel, 2'b00);
        chk("ext_internal", internal, 1'b0);
        bad = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (dtack_n !== 1'b1 || oe !== 1'b0) bad++;
        end
        chk("ext_stays_idle", bad, 0);
        release_bus();

        // Abort a $48 write on board 1 while still counting wait states.
        @(negedge clk);
        set_bus(24'hE80048, 1'b0, 1'b0, 4'h4);
        @(negedge clk);
        chk("abort_oe_in_wait", oe, 1'b1);
        got = (dtack_n === 1'b0) ? 1 : 0;
        release_bus();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (dtack_n !== 1'b1) got = 1;
        end
        chk("abort_dtack_low_seen", got, 0);
        chk("abort_oe_idle", oe, 1'b0);
        chk("abort_cfg", cfg, 2'b01);

        do_cycle(24'hE8004C, 1'b0, 4'h0, lat, nib, oe_s, sel_s);
        chk("shutup_lat", lat, EXP_LAT);
`ifdef AUTOCONFIG_SHUTUP_EN
        chk("shutup_cfg", cfg, 2'b11);
        @(negedge clk);
        set_bus(24'hE80000, 1'b1, 1'b1, 4'h0);
        #1;
        chk("shutup_ac_not_internal", internal, 1'b0);
        @(negedge clk);
        set_bus(24'h000000, 1'b0, 1'b1, 4'h0);
        #1;
        chk("shutup_b1_sel", sel, 2'b00);
        chk("shutup_b1_internal", internal, 1'b0);
        @(negedge clk);
        release_bus();
`else
        chk("shutup_ignored_cfg", cfg, 2'b01);
        @(negedge clk);
        set_bus(24'hE80000, 1'b1, 1'b1, 4'h0);
        #1;
        chk("shutup_ignored_internal", internal, 1'b1);
        do_cycle(24'hE8004A, 1'b0, 4'h0, lat, nib, oe_s, sel_s);
        do_cycle(24'hE80048, 1'b0, 4'h4, lat, nib, oe_s, sel_s);
        chk("b1_cfg", cfg, 2'b11);
        do_cycle(24'h400000, 1'b1, 4'h0, lat, nib, oe_s, sel_s);
        chk("b1_lat", lat, EXP_LAT);
        chk("b1_sel", sel_s, 2'b10);
        @(negedge clk);
        set_bus(24'h410000, 1'b0, 1'b1, 4'h0);
        #1;
        chk("b1_mask_miss_sel", sel, 2'b00);
        chk("b1_mask_miss_internal", internal, 1'b0);
        @(negedge clk);
        release_bus();
`endif

        // Reset while DTACK_n is asserted on a board-0 cycle.
        @(negedge clk);
        set_bus(24'h2A0000, 1'b0, 1'b1, 4'h0);
        got = 0;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            if (!dtack_n) begin
                got = 1;
                break;
            end
        end
        chk("rst_ack_reached", got, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_ack_dtack", dtack_n, 1'b1);
        chk("rst_ack_cfg", cfg, 2'b00);
        chk("rst_ack_oe", oe, 1'b0);
        chk("rst_ack_dout", dout, 4'hF);
        rst = 1'b0;
        release_bus();
        do_cycle(24'hE80000, 1'b1, 4'h0, lat, nib, oe_s, sel_s);
        chk("after_rst_lat", lat, EXP_LAT);
        chk("after_rst_nib", nib, 4'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
